remem_access_arbiter: RTL and testbench

//  Sequencer/arbiter placed in front of the virtual memristor crossbar. Two requesters
//  (port 0 = CPU memory stage, port 1 = secondary master, e.g. debug/DMA) share it.

---
 rtl/remem_access_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_remem_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/remem_access_arbiter.sv
// Round-robin front end for the memristor crossbar: accepts one command at a time
// from two requesters and sequences it into crossbar strobes and a single response.
//
// Handshake: a command transfers on a rising edge where reqN_valid & reqN_ready are
// both high; ready is only ever offered in IDLE and to the granted port, and a
// completion is a single-cycle rsp_valid pulse with rsp_id/rsp_data/rsp_err alongside.
module remem_access_arbiter #(
   parameter int WIDTH  = 32,
   parameter int ROWS   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [4:0]        req0_op,
   input  logic [ADDR_W-1:0] req0_rs1,
   input  logic [ADDR_W-1:0] req0_rs2,
   input  logic [ADDR_W-1:0] req0_rd,
   input  logic [WIDTH-1:0]  req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [4:0]        req1_op,
   input  logic [ADDR_W-1:0] req1_rs1,
   input  logic [ADDR_W-1:0] req1_rs2,
   input  logic [ADDR_W-1:0] req1_rd,
   input  logic [WIDTH-1:0]  req1_wdata,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_err,
   input  logic [WIDTH-1:0]  mem_data,
   output logic [31:0]       mem_control,
   output logic [31:0]       mem_word,
   output logic [WIDTH-1:0]  mem_sel_1,
   output logic [WIDTH-1:0]  mem_sel_2,
   output logic              mem_read_or_gate,
   output logic              mem_and_gate,
   output logic              mem_xor_gate,
   output logic              mem_inv_gate,
   output logic [2:0]        fsm_state
);

   localparam logic [2:0] FN_READ  = 3'd0;
   localparam logic [2:0] FN_WRITE = 3'd1;
   localparam logic [2:0] FN_OR    = 3'd2;
   localparam logic [2:0] FN_AND   = 3'd3;
   localparam logic [2:0] FN_XOR   = 3'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXEC = 3'd1,
      CAPT = 3'd2,
      WB   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t state, state_next;

   logic              last_grant;
   logic [2:0]        c_fn;
   logic              c_inv;
   logic              c_wb;
   logic              c_same;
   logic              c_id;
   logic              c_err;
   logic [ADDR_W-1:0] c_rs1;
   logic [ADDR_W-1:0] c_rs2;
   logic [ADDR_W-1:0] c_rd;
   logic [WIDTH-1:0]  c_wdata;
   logic [WIDTH-1:0]  result;

   logic              grant0, grant1, accept;
   logic [4:0]        in_op;
   logic [2:0]        in_fn;
   logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
   logic [WIDTH-1:0]  in_wdata;
   logic              in_gate, in_err;

   function automatic logic [31:0] onehot(input logic [ADDR_W-1:0] r);
      onehot = 32'd1 << r;
   endfunction

   function automatic logic bad_row(input logic [ADDR_W-1:0] r);
      bad_row = 32'(r) >= 32'(ROWS);
   endfunction

   // On a tie the port that did not win last time gets the grant.
   assign grant0 = req0_valid & (~req1_valid | last_grant);
   assign grant1 = req1_valid & (~req0_valid | ~last_grant);
   assign accept = (state == IDLE) & (grant0 | grant1);

   assign in_op    = grant1 ? req1_op    : req0_op;
   assign in_rs1   = grant1 ? req1_rs1   : req0_rs1;
   assign in_rs2   = grant1 ? req1_rs2   : req0_rs2;
   assign in_rd    = grant1 ? req1_rd    : req0_rd;
   assign in_wdata = grant1 ? req1_wdata : req0_wdata;
   assign in_fn    = in_op[2:0];
   assign in_gate  = (in_fn == FN_OR) | (in_fn == FN_AND) | (in_fn == FN_XOR);

   // Only rows the command actually touches are range-checked.
   assign in_err = (in_fn > FN_XOR)
                 | ((in_fn == FN_READ)  & bad_row(in_rs1))
                 | ((in_fn == FN_WRITE) & bad_row(in_rd))
                 | (in_gate & (bad_row(in_rs1) | bad_row(in_rs2) | (in_op[4] & bad_row(in_rd))));

   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         c_fn       <= '0;
         c_inv      <= 1'b0;
         c_wb       <= 1'b0;
         c_same     <= 1'b0;
         c_id       <= 1'b0;
         c_err      <= 1'b0;
         c_rs1      <= '0;
         c_rs2      <= '0;
         c_rd       <= '0;
         c_wdata    <= '0;
         result     <= '0;
      end else begin
         if (accept) begin
            last_grant <= grant1;
            c_fn       <= in_fn;
            c_inv      <= in_op[3] & in_gate;
            c_wb       <= in_op[4] & in_gate;
            c_same     <= in_rs1 == in_rs2;
            c_id       <= grant1;
            c_err      <= in_err;
            c_rs1      <= in_rs1;
            c_rs2      <= in_rs2;
            c_rd       <= in_rd;
            c_wdata    <= in_wdata;
            result     <= '0;
         end
         // A same-row XOR never touched the crossbar, so its result is zero.
         if (state == CAPT)
            result <= ((c_fn == FN_XOR && c_same) ? '0 : mem_data) ^ {WIDTH{c_inv}};
      end
   end

   always_comb begin
      state_next       = state;
      req0_ready       = 1'b0;
      req1_ready       = 1'b0;
      rsp_valid        = 1'b0;
      rsp_id           = 1'b0;
      rsp_data         = '0;
      rsp_err          = 1'b0;
      mem_control      = '0;
      mem_word         = '0;
      mem_sel_1        = '0;
      mem_sel_2        = '0;
      mem_read_or_gate = 1'b0;
      mem_and_gate     = 1'b0;
      mem_xor_gate     = 1'b0;
      mem_inv_gate     = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (accept) state_next = in_err ? RESP : EXEC;
         end
         EXEC: begin
            case (c_fn)
               FN_READ: begin
                  mem_control      = onehot(c_rs1);
                  mem_word         = onehot(c_rs1);
                  mem_read_or_gate = 1'b1;
               end
               FN_WRITE: begin
                  mem_control = onehot(c_rd);
                  mem_sel_1   = c_wdata;
                  mem_sel_2   = '1;
               end
               FN_OR, FN_AND: begin
                  mem_control      = onehot(c_rs1) | onehot(c_rs2);
                  mem_word         = onehot(c_rs1) | onehot(c_rs2);
                  mem_read_or_gate = 1'b1;
                  mem_and_gate     = (c_fn == FN_AND) & ~c_same;
               end
               FN_XOR: begin
                  if (!c_same) begin
                     mem_control  = onehot(c_rs1) | onehot(c_rs2);
                     mem_word     = onehot(c_rs1) | onehot(c_rs2);
                     mem_xor_gate = 1'b1;
                  end
               end
               default: ;
            endcase
            state_next = (c_fn == FN_WRITE) ? RESP : CAPT;
         end
         CAPT: state_next = c_wb ? WB : RESP;
         WB: begin
            mem_control = onehot(c_rd);
            mem_sel_1   = result;
            mem_sel_2   = '1;
            state_next  = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            rsp_id     = c_id;
            rsp_data   = result;
            rsp_err    = c_err;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_remem_access_arbiter.sv
// Directed bench for remem_access_arbiter with a behavioural crossbar model and a
// response scoreboard; row range errors are reachable because ADDR_W is widened to 6.
module tb_remem_access_arbiter;
   localparam int W  = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]    req0_op, req1_op;
   logic [AW-1:0] req0_rs1, req0_rs2, req0_rd, req1_rs1, req1_rs2, req1_rd;
   logic [W-1:0]  req0_wdata, req1_wdata;
   logic          rsp_valid, rsp_id, rsp_err;
   logic [W-1:0]  rsp_data, mem_data, mem_sel_1, mem_sel_2;
   logic [31:0]   mem_control, mem_word;
   logic          mem_read_or_gate, mem_and_gate, mem_xor_gate, mem_inv_gate;
   logic [2:0]    fsm_state;

   always #5 clk = ~clk;

   remem_access_arbiter #(.WIDTH(W), .ROWS(32), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd), .req1_wdata(req1_wdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_data(mem_data), .mem_control(mem_control), .mem_word(mem_word),
      .mem_sel_1(mem_sel_1), .mem_sel_2(mem_sel_2),
      .mem_read_or_gate(mem_read_or_gate), .mem_and_gate(mem_and_gate),
      .mem_xor_gate(mem_xor_gate), .mem_inv_gate(mem_inv_gate),
      .fsm_state(fsm_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Crossbar model: writes on sel_2 all-ones, otherwise combines the word-line rows.
   logic [W-1:0] xrow [32];

   function automatic logic [W-1:0] xb_eval(input logic [31:0] word, input logic andg, input logic xorg);
      logic [W-1:0] a;
      a = andg ? '1 : '0;
      for (int i = 0; i < 32; i++) begin
         if (word[i]) begin
            if (xorg)      a = a ^ xrow[i];
            else if (andg) a = a & xrow[i];
            else           a = a | xrow[i];
         end
      end
      return a;
   endfunction

   always @(posedge clk) begin
      if (mem_sel_2 == '1) begin
         for (int i = 0; i < 32; i++) if (mem_control[i]) xrow[i] <= mem_sel_1;
      end else if (mem_read_or_gate || mem_xor_gate) begin
         mem_data <= xb_eval(mem_word, mem_and_gate, mem_xor_gate);
      end
   end

   int           strobe_cnt = 0;
   int           inv_cnt = 0;
   logic [31:0]  last_control, last_gword;
   logic [W-1:0] last_sel1, last_sel2;
   logic [2:0]   last_gate;
   always @(negedge clk) begin
      if ((mem_control | mem_word) != 0 || (mem_sel_1 | mem_sel_2) != 0 ||
          mem_read_or_gate || mem_and_gate || mem_xor_gate) begin
         strobe_cnt   <= strobe_cnt + 1;
         last_control <= mem_control;
         last_sel1    <= mem_sel_1;
         last_sel2    <= mem_sel_2;
      end
      if (mem_read_or_gate || mem_xor_gate) begin
         last_gate  <= {mem_read_or_gate, mem_and_gate, mem_xor_gate};
         last_gword <= mem_word;
      end
      if (mem_inv_gate) inv_cnt <= inv_cnt + 1;
   end

   int               checks = 0;
   int               errors = 0;
   logic [W+1:0]     exp_q[$];
   int               lat_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [4:0] op, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic [W-1:0] wdata);
      if (p == 0) begin
         req0_valid = v; req0_op = op; req0_rs1 = rs1; req0_rs2 = rs2; req0_rd = rd; req0_wdata = wdata;
      end else begin
         req1_valid = v; req1_op = op; req1_rs1 = rs1; req1_rs2 = rs2; req1_rd = rd; req1_wdata = wdata;
      end
   endtask

   // Waits for a grant, scores it, then waits for and scores the matching response.
   task automatic take(input string tag, input logic exp_id, input logic [W-1:0] exp_data,
                       input logic exp_err, input int exp_lat, input int exp_strb);
      int           n, acc, s0;
      logic         got, saw_ready;
      logic [W+1:0] e;
      int           l;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
         tick();
         n++;
      end
      check({tag, " accept"}, req0_ready | req1_ready, 1'b1);
      if (!(req0_ready || req1_ready)) return;
      check({tag, " one_ready"}, req0_ready & req1_ready, 1'b0);
      check({tag, " grant"}, req1_ready, exp_id);
      exp_q.push_back({exp_id, exp_err, exp_data});
      lat_q.push_back(exp_lat);
      acc = cyc;
      s0  = strobe_cnt;
      @(posedge clk);
      tick();
      got = 1'b0;
      saw_ready = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (rsp_valid) got = 1'b1;
         else begin
            if (req0_ready || req1_ready) saw_ready = 1'b1;
            tick();
         end
      end
      check({tag, " rsp_seen"}, got, 1'b1);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      if (got) begin
         check({tag, " id"}, rsp_id, e[W+1]);
         check({tag, " err"}, rsp_err, e[W]);
         check({tag, " data"}, rsp_data, e[W-1:0]);
         check({tag, " latency"}, cyc - acc, l);
         check({tag, " strobe_cycles"}, strobe_cnt - s0, exp_strb);
         check({tag, " ready_in_flight"}, saw_ready, 1'b0);
      end
   endtask

   task automatic send(input string tag, input int p, input logic [4:0] op, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic [W-1:0] wdata,
                       input logic [W-1:0] exp_data, input logic exp_err, input int exp_lat, input int exp_strb);
      tick();
      set_req(p, 1'b1, op, rs1, rs2, rd, wdata);
      #1;
      take(tag, p[0], exp_data, exp_err, exp_lat, exp_strb);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      logic exp_id;
      int   seen;
      set_req(0, 1'b0, '0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0, '0);
      rst = 1'b1;
      repeat (3) tick();
      check("reset state", fsm_state, 3'd0);
      check("reset rsp_valid", rsp_valid, 1'b0);
      check("reset rsp_data", rsp_data, 32'h0);
      check("reset control", mem_control, 32'h0);
      check("reset sel_2", mem_sel_2, 32'h0);
      rst = 1'b0;
      tick();

      // Writes and a write/read of the highest legal row.
      send("wr3", 0, 5'b00001, 0, 0, 3, 32'hA5A5_0F0F, 32'h0, 1'b0, 2, 1);
      check("wr3 control", last_control, 32'h8);
      check("wr3 sel_2", last_sel2, 32'hFFFF_FFFF);
      check("wr3 sel_1", last_sel1, 32'hA5A5_0F0F);
      send("wr4", 0, 5'b00001, 0, 0, 4, 32'h0F0F_FFFF, 32'h0, 1'b0, 2, 1);
      send("wr31", 0, 5'b00001, 0, 0, 31, 32'h1234_5678, 32'h0, 1'b0, 2, 1);
      send("rd31", 1, 5'b00000, 31, 40, 0, 32'h0, 32'h1234_5678, 1'b0, 3, 1);

      // Gates, inversion and write-back.
      send("and_inv_wb", 1, 5'b11011, 3, 4, 5, 32'h0, 32'hFAFA_F0F0, 1'b0, 4, 2);
      check("and gates", last_gate, 3'b110);
      check("and word", last_gword, 32'h18);
      check("wb control", last_control, 32'h20);
      check("wb sel_1", last_sel1, 32'hFAFA_F0F0);
      send("rd5", 0, 5'b00000, 5, 0, 0, 32'h0, 32'hFAFA_F0F0, 1'b0, 3, 1);
      check("rd5 word", last_gword, 32'h20);
      send("or34", 1, 5'b00010, 3, 4, 0, 32'h0, 32'hAFAF_FFFF, 1'b0, 3, 1);
      check("or gates", last_gate, 3'b100);
      send("xor34_inv", 0, 5'b01100, 3, 4, 0, 32'h0, 32'h5555_0F0F, 1'b0, 3, 1);
      check("xor gates", last_gate, 3'b001);
      send("rd_ignores_inv_wb", 1, 5'b11000, 3, 0, 9, 32'h0, 32'hA5A5_0F0F, 1'b0, 3, 1);

      // Both ports always valid: grants alternate starting with port 0.
      tick();
      set_req(0, 1'b1, 5'b00000, 3, 0, 0, 32'h0);
      set_req(1, 1'b1, 5'b00000, 4, 0, 0, 32'h0);
      #1;
      exp_id = 1'b0;
      for (int k = 0; k < 4; k++) begin
         take($sformatf("rr%0d", k), exp_id, exp_id ? 32'h0F0F_FFFF : 32'hA5A5_0F0F, 1'b0, 3, 1);
         exp_id = ~exp_id;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Same-row gates.
      send("xor77", 0, 5'b00100, 7, 7, 0, 32'h0, 32'h0, 1'b0, 3, 0);
      send("xor77_inv", 1, 5'b01100, 7, 7, 0, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 0);
      send("or33", 0, 5'b00010, 3, 3, 0, 32'h0, 32'hA5A5_0F0F, 1'b0, 3, 1);
      check("or33 as read", last_gate, 3'b100);
      check("or33 word", last_gword, 32'h8);
      send("and44_inv_wb", 1, 5'b11011, 4, 4, 6, 32'h0, 32'hF0F0_0000, 1'b0, 4, 2);
      check("and44 as read", last_gate, 3'b100);
      send("rd6", 0, 5'b00000, 6, 0, 0, 32'h0, 32'hF0F0_0000, 1'b0, 3, 1);

      // Errors: illegal fn and out-of-range rows that the command uses.
      send("fn6", 1, 5'b00110, 0, 0, 0, 32'h0, 32'h0, 1'b1, 1, 0);
      send("rd40", 0, 5'b00000, 40, 0, 0, 32'h0, 32'h0, 1'b1, 1, 0);
      send("wr33", 1, 5'b00001, 0, 0, 33, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0);
      send("xor_rs2_63", 0, 5'b00100, 3, 63, 0, 32'h0, 32'h0, 1'b1, 1, 0);
      send("or_wb_rd50", 1, 5'b10010, 3, 4, 50, 32'h0, 32'h0, 1'b1, 1, 0);
      send("and_rd50_unused", 0, 5'b00011, 3, 4, 50, 32'h0, 32'h0505_0F0F, 1'b0, 3, 1);

      // Reset while a READ is in CAPT drops it.
      tick();
      set_req(0, 1'b1, 5'b00000, 3, 0, 0, 32'h0);
      #1;
      check("t6 ready", req0_ready, 1'b1);
      @(posedge clk);
      tick();
      req0_valid = 1'b0;
      check("t6 exec", fsm_state, 3'd1);
      @(posedge clk);
      tick();
      check("t6 capt", fsm_state, 3'd2);
      rst = 1'b1;
      #1;
      check("t6 rst state", fsm_state, 3'd0);
      check("t6 rst rsp_valid", rsp_valid, 1'b0);
      check("t6 rst rsp_data", rsp_data, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         if (rsp_valid) seen++;
         tick();
      end
      check("t6 no rsp", seen, 0);
      set_req(0, 1'b1, 5'b00000, 3, 0, 0, 32'h0);
      set_req(1, 1'b1, 5'b00000, 4, 0, 0, 32'h0);
      #1;
      take("post_rst0", 1'b0, 32'hA5A5_0F0F, 1'b0, 3, 1);
      take("post_rst1", 1'b1, 32'h0F0F_FFFF, 1'b0, 3, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      check("inv_gate never", inv_cnt, 0);
      check("queue empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
